iir_coeff_loader: RTL and testbench
===================================

# iir_coeff_loader

Upstream coefficient-staging stage for the 2nd-order IIR filter. It receives coefficient writes from the PS-side GPIO as (address, data, strobe) transactions into a shadow bank. A commit request copies the whole bank to the active outputs atomically, aligned to a filter sample strobe. The filter therefore never runs a sample with a mixed old/new coefficient set. Its outputs drive the filter's b0, b1, b2, a1, a2 and gain inputs directly.

## Interface
- COEFF_WIDTH, 32, width of every coefficient and of wr_data
- LOG_A0, 30, b0 reset value is 2^LOG_A0 (unity pass-through)
- LOG_UNITY_GAIN, 16, gain reset value is 2^LOG_UNITY_GAIN
- RAMP_STEP_LOG, 8, gain ramp step is 2^RAMP_STEP_LOG (used only with GAIN_RAMP_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  shadow write strobe, one write per high cycle
- wr_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2, 5=gain, 6/7 invalid
- wr_data  in  COEFF_WIDTH  signed coefficient value
- commit  in  1  request transfer of shadow to active, level-sampled each cycle
- sample_tick  in  1  one-cycle strobe marking a filter sample boundary
- err_clr  in  1  clears err
- b0, b1, b2, a1, a2, gain  out  COEFF_WIDTH each  active signed coefficients, registered
- busy  out  1  high in any state other than IDLE
- commit_done  out  1  one-cycle pulse when the commit has fully taken effect
- err  out  1  sticky error flag

## Operation
- Reset: the active and shadow banks hold b0=2^LOG_A0, gain=2^LOG_UNITY_GAIN, and all other coefficients 0. State is IDLE; busy, commit_done and err are 0.
- Shadow write: when wr_en is high with a valid address, the shadow register is updated at the next edge. An invalid address (6 or 7) sets err and writes nothing.
- Writes during ARMED or APPLY are ignored and set err. Writes during RAMP are accepted, because the ramp target is a separate register.
- FSM states: IDLE, ARMED, APPLY, RAMP (RAMP exists only with GAIN_RAMP_EN).
  - IDLE: commit=1 moves to ARMED. If commit and sample_tick are high in the same cycle, the tick is not used and the block waits for the next one.
  - ARMED: sample_tick=1 moves to APPLY.
  - APPLY: lasts one cycle. The shadow bank is copied to the active bank, then the FSM goes to IDLE (or to RAMP, see Configuration).
  - commit while busy is ignored and sets err.
- err stays set until err_clr=1. If err_clr and a new error occur in the same cycle, the error wins and err stays 1.
- Arithmetic: copies are bit-exact with no saturation. Ramp arithmetic is signed COEFF_WIDTH+1 bits internally.

## Timing
- Write latency: the shadow register is updated 1 edge after wr_en.
- Commit: commit is sampled at edge t, giving ARMED at t+1. sample_tick is sampled at edge k, giving APPLY at k+1. Active outputs change together at edge k+2.
- Without ramp, commit_done is high during the cycle after edge k+2 and busy falls at edge k+2.
- Minimum commit-to-output latency is 3 cycles (when sample_tick is high the cycle after commit).
- A reset assertion at any point is asynchronous and immediate. It discards any pending commit or ramp and restores all reset values.

## Configuration
- GAIN_RAMP_EN, when defined:
  - APPLY updates b0..a2 only and latches the shadow gain as the target.
  - In RAMP, on each sample_tick the gain moves toward the target by min(|target−gain|, 2^RAMP_STEP_LOG).
  - When gain equals the target, the FSM goes to IDLE and commit_done pulses at that transition.
  - If the target already equals gain at APPLY, the FSM goes straight to IDLE with the same timing as the non-ramp case.
- Not defined: gain is copied in APPLY together with the other coefficients. The RAMP state and ramp logic are absent.

## Test plan
- Reset release: outputs are b0=0x40000000, gain=0x00010000, b1=b2=a1=a2=0; busy=0, err=0.
- Write b1=0x12345678 and a1=0xC0000000, then commit with sample_tick 5 cycles later: outputs are unchanged until the tick, both update on the same edge (tick+2), and commit_done pulses once.
- Write to address 6 → err=1 with no shadow change. A commit issued while ARMED → err stays 1 and there is no second commit_done. err_clr → err=0.
- Write b0 while ARMED → ignored and err=1. After the tick, b0 equals the pre-ARMED shadow value.
- GAIN_RAMP_EN, RAMP_STEP_LOG=8, gain committed 0x10000→0x10300: gain steps 0x10100, 0x10200, 0x10300 on three successive ticks, then commit_done fires.
- Assert rst while in RAMP (or ARMED): outputs immediately return to reset values and a later tick causes no update.

Source files
------------

// File: rtl/iir_coeff_loader.sv
// Coefficient shadow/active bank for the 2nd-order IIR filter; commits land on a sample boundary.
// Optional feature macro: GAIN_RAMP_EN (gain ramps toward the committed value instead of jumping).
module iir_coeff_loader #(
  parameter int COEFF_WIDTH    = 32,
  parameter int LOG_A0         = 30,
  parameter int LOG_UNITY_GAIN = 16,
  parameter int RAMP_STEP_LOG  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [2:0]             wr_addr,
  input  logic [COEFF_WIDTH-1:0] wr_data,
  input  logic                   commit,
  input  logic                   sample_tick,
  input  logic                   err_clr,
  output logic [COEFF_WIDTH-1:0] b0,
  output logic [COEFF_WIDTH-1:0] b1,
  output logic [COEFF_WIDTH-1:0] b2,
  output logic [COEFF_WIDTH-1:0] a1,
  output logic [COEFF_WIDTH-1:0] a2,
  output logic [COEFF_WIDTH-1:0] gain,
  output logic                   busy,
  output logic                   commit_done,
  output logic                   err
);

  localparam logic [COEFF_WIDTH-1:0] B0_RST   = COEFF_WIDTH'(1) << LOG_A0;
  localparam logic [COEFF_WIDTH-1:0] GAIN_RST = COEFF_WIDTH'(1) << LOG_UNITY_GAIN;

  if (RAMP_STEP_LOG >= COEFF_WIDTH) begin : g_bad_step
    $error("RAMP_STEP_LOG must be smaller than COEFF_WIDTH");
  end

`ifdef GAIN_RAMP_EN
  typedef enum logic [1:0] {IDLE, ARMED, APPLY, RAMP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_t;
`endif

  state_t state;
  logic   commit_q, tick_q;
  logic [COEFF_WIDTH-1:0] sh_b0, sh_b1, sh_b2, sh_a1, sh_a2, sh_gain;
  logic   wr_invalid, wr_blocked, wr_ok, commit_err, new_err;

  assign wr_invalid = wr_en && (wr_addr > 3'd5);
  assign wr_blocked = wr_en && ((state == ARMED) || (state == APPLY));
  assign wr_ok      = wr_en && !wr_invalid && !wr_blocked;
  assign commit_err = commit_q && (state != IDLE);
  assign new_err    = wr_invalid || wr_blocked || commit_err;

`ifdef GAIN_RAMP_EN
  localparam logic [COEFF_WIDTH-1:0] STEP_U    = COEFF_WIDTH'(1) << RAMP_STEP_LOG;
  localparam logic signed [COEFF_WIDTH:0] STEP_S = $signed({1'b0, STEP_U});
  logic [COEFF_WIDTH-1:0]        gain_target;
  logic signed [COEFF_WIDTH:0]   ramp_diff;

  // One extra bit so the difference of two extreme signed values cannot wrap.
  assign ramp_diff = $signed({gain_target[COEFF_WIDTH-1], gain_target})
                   - $signed({gain[COEFF_WIDTH-1], gain});
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_b0   <= B0_RST;
      sh_b1   <= '0;
      sh_b2   <= '0;
      sh_a1   <= '0;
      sh_a2   <= '0;
      sh_gain <= GAIN_RST;
    end else if (wr_ok) begin
      case (wr_addr)
        3'd0:    sh_b0   <= wr_data;
        3'd1:    sh_b1   <= wr_data;
        3'd2:    sh_b2   <= wr_data;
        3'd3:    sh_a1   <= wr_data;
        3'd4:    sh_a2   <= wr_data;
        3'd5:    sh_gain <= wr_data;
        default: ;
      endcase
    end
  end

  // commit and sample_tick are registered first, so the FSM acts one edge after sampling them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      commit_q    <= 1'b0;
      tick_q      <= 1'b0;
      b0          <= B0_RST;
      b1          <= '0;
      b2          <= '0;
      a1          <= '0;
      a2          <= '0;
      gain        <= GAIN_RST;
      busy        <= 1'b0;
      commit_done <= 1'b0;
      err         <= 1'b0;
`ifdef GAIN_RAMP_EN
      gain_target <= GAIN_RST;
`endif
    end else begin
      commit_q    <= commit;
      tick_q      <= sample_tick;
      commit_done <= 1'b0;
      err         <= new_err || (err && !err_clr);
      case (state)
        IDLE: begin
          if (commit_q) begin
            state <= ARMED;
            busy  <= 1'b1;
          end
        end
        ARMED: begin
          if (tick_q) state <= APPLY;
        end
        APPLY: begin
          b0 <= sh_b0;
          b1 <= sh_b1;
          b2 <= sh_b2;
          a1 <= sh_a1;
          a2 <= sh_a2;
`ifdef GAIN_RAMP_EN
          gain_target <= sh_gain;
          if (sh_gain == gain) begin
            state       <= IDLE;
            busy        <= 1'b0;
            commit_done <= 1'b1;
          end else begin
            state <= RAMP;
          end
`else
          gain        <= sh_gain;
          state       <= IDLE;
          busy        <= 1'b0;
          commit_done <= 1'b1;
`endif
        end
`ifdef GAIN_RAMP_EN
        RAMP: begin
          if (tick_q) begin
            if (ramp_diff > STEP_S) begin
              gain <= gain + STEP_U;
            end else if (ramp_diff < -STEP_S) begin
              gain <= gain - STEP_U;
            end else begin
              gain        <= gain_target;
              state       <= IDLE;
              busy        <= 1'b0;
              commit_done <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Self-checking bench for iir_coeff_loader: a scoreboard of committed banks checked on commit_done.
// Compile with +define+GAIN_RAMP_EN to also exercise the gain ramp.
module tb_iir_coeff_loader;

  typedef struct packed {
    logic [31:0] b0, b1, b2, a1, a2, gain;
  } bank_t;

  logic        clk, rst;
  logic        wr_en, commit, sample_tick, err_clr;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] b0, b1, b2, a1, a2, gain;
  logic        busy, commit_done, err;

  int    n_checks = 0;
  int    n_fails  = 0;
  int    done_count = 0;
  int    exp_done = 0;
  bank_t mdl;
  bank_t expq[$];

  iir_coeff_loader #(
    .COEFF_WIDTH(32), .LOG_A0(30), .LOG_UNITY_GAIN(16), .RAMP_STEP_LOG(8)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .sample_tick(sample_tick), .err_clr(err_clr),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2), .gain(gain),
    .busy(busy), .commit_done(commit_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic resetModel();
    mdl = '{b0: 32'h4000_0000, b1: 32'h0, b2: 32'h0, a1: 32'h0, a2: 32'h0, gain: 32'h0001_0000};
  endtask

  // Drives one cycle of stimulus, then returns inputs to idle just after the sampling edge.
  task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [31:0] data,
                               input logic cm, input logic tk, input logic clr);
    wr_en = we; wr_addr = addr; wr_data = data;
    commit = cm; sample_tick = tk; err_clr = clr;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 32'h0;
    commit = 1'b0; sample_tick = 1'b0; err_clr = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic writeCoeff(input logic [2:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data, 1'b0, 1'b0, 1'b0);
    case (addr)
      3'd0: mdl.b0 = data;
      3'd1: mdl.b1 = data;
      3'd2: mdl.b2 = data;
      3'd3: mdl.a1 = data;
      3'd4: mdl.a2 = data;
      3'd5: mdl.gain = data;
      default: ;
    endcase
  endtask

  task automatic issueCommit();
    expq.push_back(mdl);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  // Scoreboard: every commit_done must match the oldest committed bank.
  always @(negedge clk) begin
    if (!rst && commit_done) begin
      bank_t e;
      done_count++;
      checkOutput("sb_pending", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("sb_b0", b0, e.b0);
        checkOutput("sb_b1", b1, e.b1);
        checkOutput("sb_b2", b2, e.b2);
        checkOutput("sb_a1", a1, e.a1);
        checkOutput("sb_a2", a2, e.a2);
        checkOutput("sb_gain", gain, e.gain);
      end
    end
  end

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 32'h0;
    commit = 1'b0; sample_tick = 1'b0; err_clr = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    waitCycles(1);
    checkOutput("rst_b0", b0, 32'h4000_0000);
    checkOutput("rst_b1", b1, 32'h0);
    checkOutput("rst_b2", b2, 32'h0);
    checkOutput("rst_a1", a1, 32'h0);
    checkOutput("rst_a2", a2, 32'h0);
    checkOutput("rst_gain", gain, 32'h0001_0000);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_done", 32'(commit_done), 32'd0);

    // Two writes, commit, tick five cycles later: outputs move together at tick+2.
    writeCoeff(3'd1, 32'h1234_5678);
    writeCoeff(3'd3, 32'hC000_0000);
    issueCommit();
    waitCycles(1);
    checkOutput("armed_busy", 32'(busy), 32'd1);
    waitCycles(3);
    checkOutput("pre_tick_b1", b1, 32'h0);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    waitCycles(1);
    checkOutput("tick1_b1", b1, 32'h0);
    checkOutput("tick1_a1", a1, 32'h0);
    waitCycles(1);
    checkOutput("tick2_b1", b1, 32'h1234_5678);
    checkOutput("tick2_a1", a1, 32'hC000_0000);
    checkOutput("tick2_busy", 32'(busy), 32'd0);
    checkOutput("tick2_done", 32'(commit_done), 32'd1);
    waitCycles(1);
    exp_done++;
    checkOutput("done_once", 32'(done_count), 32'(exp_done));
    checkOutput("done_low", 32'(commit_done), 32'd0);

    // Error paths: invalid address, commit while ARMED, write while ARMED, err_clr.
    applyStimulus(1'b1, 3'd6, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    checkOutput("inv_addr_err", 32'(err), 32'd1);
    issueCommit();
    waitCycles(1);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("busy_commit_err", 32'(err), 32'd1);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_err", 32'(err), 32'd0);
    applyStimulus(1'b1, 3'd0, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    checkOutput("armed_wr_err", 32'(err), 32'd1);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_err2", 32'(err), 32'd0);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    waitCycles(2);
    checkOutput("armed_wr_b0", b0, 32'h4000_0000);
    waitCycles(1);
    exp_done++;
    checkOutput("no_second_done", 32'(done_count), 32'(exp_done));
    applyStimulus(1'b1, 3'd7, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("err_wins_clr", 32'(err), 32'd1);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_err3", 32'(err), 32'd0);

    // Extreme values and minimum latency: tick right after commit, outputs at commit+3.
    writeCoeff(3'd0, 32'h7FFF_FFFF);
    writeCoeff(3'd1, 32'h0000_0001);
    writeCoeff(3'd2, 32'h8000_0000);
    writeCoeff(3'd4, 32'hFFFF_FFFF);
`ifndef GAIN_RAMP_EN
    writeCoeff(3'd5, 32'h0002_0000);
`endif
    issueCommit();
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    waitCycles(1);
    checkOutput("minlat_b2_old", b2, 32'h0);
    waitCycles(1);
    checkOutput("minlat_b2_new", b2, 32'h8000_0000);
    checkOutput("minlat_b0_new", b0, 32'h7FFF_FFFF);
    waitCycles(1);
    exp_done++;
    checkOutput("minlat_done", 32'(done_count), 32'(exp_done));

`ifdef GAIN_RAMP_EN
    // Gain ramps 0x10000 -> 0x10300 in 0x100 steps, one per tick.
    writeCoeff(3'd5, 32'h0001_0300);
    issueCommit();
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    waitCycles(2);
    checkOutput("ramp_start_gain", gain, 32'h0001_0000);
    checkOutput("ramp_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0);
      waitCycles(1);
      checkOutput("ramp_gain", gain, 32'h0001_0000 + 32'(i) * 32'h100);
      checkOutput("ramp_done", 32'(commit_done), (i == 3) ? 32'd1 : 32'd0);
    end
    waitCycles(1);
    exp_done++;
    checkOutput("ramp_done_cnt", 32'(done_count), 32'(exp_done));
    checkOutput("ramp_idle", 32'(busy), 32'd0);
`endif

    // Asynchronous reset while ARMED drops the pending commit.
    issueCommit();
    waitCycles(2);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_b0", b0, 32'h4000_0000);
    checkOutput("arst_b1", b1, 32'h0);
    checkOutput("arst_gain", gain, 32'h0001_0000);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    expq.delete();
    resetModel();
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    waitCycles(3);
    checkOutput("arst_no_apply_b1", b1, 32'h0);
    checkOutput("arst_no_done", 32'(done_count), 32'(exp_done));
    checkOutput("sb_empty", 32'(expq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
